// File: rtl/dbus_access_if.sv
// Memory-stage request, data-bus request/response and load-result signals of dbus_access.
// The master modport is the access unit's view; slave is the pipeline/memory side.
interface dbus_access_if;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic [1:0]  dreq_size;

  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  logic [31:0] m_data;
  logic        stall;
  logic        done;
  logic        misalign;

  modport master (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data, dreq_size,
    output m_data, stall, done, misalign
  );

  modport slave (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data, dreq_size,
    input  m_data, stall, done, misalign
  );
endinterface

// File: rtl/dbus_access.sv
// Memory-stage data-bus access FSM: one load/store at a time, done one cycle after data_ok.
// Optional DBUS_MISALIGN_CHECK_EN traps misaligned half/word accesses without touching the bus.
module dbus_access (
  input  logic          clk,
  input  logic          resetn,
  dbus_access_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [3:0]  strobe_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        load_q;
  logic        uns_q;
  logic [31:0] m_data_q;
  logic        misalign_q;

  logic        accept;
  logic        misal;
  logic        complete;
  logic [1:0]  size_n;
  logic [3:0]  st_strobe;
  logic [31:0] st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  assign accept   = (state == IDLE) && bus.req_valid && (bus.req_load || bus.req_store);
  assign size_n   = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
  assign complete = ((state == REQ) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                    ((state == WAIT) && bus.dresp_data_ok);

`ifdef DBUS_MISALIGN_CHECK_EN
  assign misal = ((size_n == 2'd1) && bus.req_addr[0]) ||
                 ((size_n == 2'd2) && (bus.req_addr[1:0] != 2'd0));
`else
  assign misal = 1'b0;
`endif

  // Store lanes are laid out here so the bus sees memory-lane-aligned data and byte enables.
  always_comb begin
    st_strobe = 4'b1111;
    st_data   = bus.req_wdata;
    case (size_n)
      2'd0: begin
        st_strobe = 4'b0001 << bus.req_addr[1:0];
        st_data   = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        st_strobe = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_data   = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = bus.dresp_data[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = bus.dresp_data[15:8];
      2'd2:    lane_b = bus.dresp_data[23:16];
      2'd3:    lane_b = bus.dresp_data[31:24];
      default: ;
    endcase
    lane_h   = addr_q[1] ? bus.dresp_data[31:16] : bus.dresp_data[15:0];
    load_fmt = bus.dresp_data;
    case (size_q)
      2'd0:    load_fmt = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_fmt = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      strobe_q   <= 4'h0;
      data_q     <= 32'h0;
      size_q     <= 2'd0;
      load_q     <= 1'b0;
      uns_q      <= 1'b0;
      m_data_q   <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= bus.req_addr;
            size_q     <= size_n;
            load_q     <= bus.req_load;
            uns_q      <= bus.req_unsigned;
            strobe_q   <= bus.req_store ? st_strobe : 4'h0;
            data_q     <= bus.req_store ? st_data : 32'h0;
            misalign_q <= misal;
            state      <= misal ? DONE : REQ;
          end
        end
        REQ: begin
          if (bus.dresp_addr_ok) state <= bus.dresp_data_ok ? DONE : WAIT;
        end
        WAIT: begin
          if (bus.dresp_data_ok) state <= DONE;
        end
        default: begin
          state      <= IDLE;
          misalign_q <= 1'b0;
        end
      endcase
      if (complete && load_q) m_data_q <= load_fmt;
    end
  end

  assign bus.dreq_valid  = (state == REQ);
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_data   = data_q;
  assign bus.dreq_size   = size_q;
  assign bus.m_data      = m_data_q;
  assign bus.stall       = accept || (state == REQ) || (state == WAIT);
  assign bus.done        = (state == DONE);
  assign bus.misalign    = misalign_q;
endmodule

// File: doc/dbus_access.md
DBUS_ACCESS -- requirements
Module: dbus_access

Interface
REQ-001 SHALL use clk, input, 1, clock; resetn, input, 1, reset: synchronous, active-low (resetn is sampled on the rising edge of clk).
REQ-002 SHALL have req_valid, input, 1, memory-stage instruction present; req_load and req_store, input, 1 each, operation type, mutually exclusive.
REQ-003 SHALL have req_size, input, 2, access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
REQ-004 SHALL have req_unsigned, input, 1, zero-extend load; req_addr, input, 32, byte address; req_wdata, input, 32, store data (low-aligned).
REQ-005 SHALL have dreq_valid, output, 1; dreq_addr, output, 32; dreq_strobe, output, 4; dreq_data, output, 32; dreq_size, output, 2.
REQ-006 SHALL have dresp_addr_ok, input, 1; dresp_data_ok, input, 1; dresp_data, input, 32, bus responses.
REQ-007 SHALL have m_data, output, 32, formatted load result; stall, output, 1, hold pipeline; done, output, 1, access complete; misalign, output, 1, misaligned-access flag.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-009 SHALL, in IDLE with req_valid and (req_load or req_store) sampled, capture addr, size, unsigned, load and formatted store data, and enter REQ.
REQ-010 SHALL assert dreq_valid only in REQ, with dreq_* driven from the captured registers and held stable until dresp_addr_ok.
REQ-011 SHALL transition REQ to DONE if dresp_addr_ok and dresp_data_ok occur in the same cycle, REQ to WAIT on dresp_addr_ok alone, WAIT to DONE on dresp_data_ok, and DONE to IDLE unconditionally.
REQ-012 SHALL register m_data on the completing cycle for loads, and hold m_data unchanged for stores.
REQ-013 SHALL drive stall combinationally as (IDLE and req_valid and (req_load or req_store)) or REQ or WAIT; stall SHALL be 0 in DONE.
REQ-014 SHALL assert done for exactly the one cycle spent in DONE.
REQ-015 SHALL produce store strobes as follows: byte, 4'b0001 shifted by addr[1:0]; half, 4'b0011 shifted by 2*addr[1]; word, 4'b1111.
REQ-016 SHALL replicate store data as follows: byte data copied into all 4 lanes; half data copied into both halves.
REQ-017 SHALL format load data as follows: byte lane addr[1:0] or half lane addr[1], sign-extended, or zero-extended when req_unsigned is set; word loads pass through unchanged.
REQ-018 SHALL ignore dresp_addr_ok and dresp_data_ok in IDLE and DONE, and dresp_data_ok in REQ before dresp_addr_ok.
REQ-019 SHALL ignore req_valid while not in IDLE; a new request is accepted no earlier than the IDLE cycle following DONE.
REQ-020 SHALL issue no bus request when req_valid=1 but neither req_load nor req_store is set, and stall SHALL then be 0.

Reset
REQ-021 SHALL, on resetn=0, force IDLE and clear dreq_valid, dreq_addr, dreq_strobe, dreq_data, dreq_size, m_data, done and misalign to 0 at the next edge.
REQ-022 SHALL abandon an in-flight transaction on reset; bus responses arriving afterwards are ignored per REQ-018.

Configuration
REQ-023 SHALL gate misalignment checking with macro DBUS_MISALIGN_CHECK_EN.
REQ-024 SHALL, with DBUS_MISALIGN_CHECK_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 in IDLE as follows: no bus request is issued, the FSM enters DONE directly, and misalign=1 together with done=1 for that one cycle.
REQ-025 SHALL, without DBUS_MISALIGN_CHECK_EN, tie misalign to 0 and issue every access on the bus using the address as given.

Verification
REQ-026 SHALL cover a word load at addr 0x1000 with addr_ok+data_ok in the same cycle and dresp_data=0x89ABCDEF -> dreq_valid for 1 cycle, m_data=0x89ABCDEF, done 2 cycles after acceptance.
REQ-027 SHALL cover a signed byte load at addr 0x1003 with dresp_data=0x80112233 -> m_data=0xFFFFFF80; the same access with req_unsigned=1 -> m_data=0x00000080.
REQ-028 SHALL cover a half store at addr 0x2002 with req_wdata=0x0000BEEF -> dreq_strobe=4'b1100, dreq_data=0xBEEFBEEF.
REQ-029 SHALL cover addr_ok delayed 3 cycles then data_ok delayed 2 cycles -> dreq_* stable throughout, stall=1 continuously until DONE, done for 1 cycle.
REQ-030 SHALL cover resetn=0 asserted in WAIT, followed by a late data_ok -> IDLE, dreq_valid=0, m_data=0, done stays 0.
REQ-031 SHALL cover a word load at addr 0x1002 -> with DBUS_MISALIGN_CHECK_EN: misalign=1, done=1, dreq_valid never 1; without it: normal bus access, misalign=0.
